sseg4_scan_ctrl: RTL and testbench

//   Upstream driver for the 4-digit seven-segment decoder (sseg4). Generates the

---
 rtl/sseg4_scan_ctrl_if.sv | 24 ++
 rtl/sseg4_scan_ctrl.sv | 81 ++++++++
 tb/tb_sseg4_scan_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sseg4_scan_ctrl_if.sv
// Display-data and scan signals between a display source and sseg4_scan_ctrl.
// The master side drives en/load/data_in; the slave side (the controller) drives
// data_out, digit_sel, frame_tick and update_pending.
interface sseg4_scan_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              en;
  logic              load;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        digit_sel;
  logic              frame_tick;
  logic              update_pending;

  modport master (
    output en, load, data_in,
    input  data_out, digit_sel, frame_tick, update_pending
  );

  modport slave (
    input  en, load, data_in,
    output data_out, digit_sel, frame_tick, update_pending
  );
endinterface

// File: rtl/sseg4_scan_ctrl.sv
// Scan controller for a 4-digit seven-segment decoder: refresh prescaler, digit
// scan and a double-buffered data word that only changes at a frame boundary.
// All outputs are registered; a new word reaches data_out at the next digit 3->0 wrap.
module sseg4_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int DATA_W      = 16
) (
  input logic             clk,
  input logic             reset,
  sseg4_scan_ctrl_if.slave bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]     prescaler;
  logic [1:0]        digit_sel;
  logic              frame_tick;
  logic [DATA_W-1:0] pending;
  logic [DATA_W-1:0] data_out;
  logic              update_pending;

  logic slot_end;
  logic fb;

  // End of a digit slot and end of a whole frame (after digit 3).
  always_comb begin
    slot_end = bus.en && (prescaler == LAST);
    fb       = slot_end && (digit_sel == 2'd3);
  end

  // Prescaler and digit scan; both freeze while en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      digit_sel <= 2'd0;
    end else if (bus.en) begin
      if (slot_end) begin
        prescaler <= '0;
        digit_sel <= digit_sel + 2'd1;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

  // One-cycle frame pulse registered on the wrap edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= fb;
    end
  end

  // Double buffer: a load lands in pending; the commit at fb uses the pre-edge
  // pending value, so a load on the fb cycle itself waits for the following frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending        <= '0;
      data_out       <= '0;
      update_pending <= 1'b0;
    end else begin
      if (fb && update_pending) begin
        data_out <= pending;
      end
      if (bus.load) begin
        pending        <= bus.data_in;
        update_pending <= 1'b1;
      end else if (fb) begin
        update_pending <= 1'b0;
      end
    end
  end

  assign bus.data_out       = data_out;
  assign bus.digit_sel      = digit_sel;
  assign bus.frame_tick     = frame_tick;
  assign bus.update_pending = update_pending;

endmodule

// File: tb/tb_sseg4_scan_ctrl.sv
// Directed bench for sseg4_scan_ctrl with REFRESH_DIV=4: scan timing, frame pulse,
// double-buffered commits, en freeze and asynchronous reset.
module tb_sseg4_scan_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   eff;
  logic exp_ft;

  sseg4_scan_ctrl_if #(.DATA_W(16)) bus ();

  sseg4_scan_ctrl #(.REFRESH_DIV(4), .DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.en      = 1'b0;
    bus.load    = 1'b0;
    bus.data_in = 16'h0000;

    step();
    step();
    check("rst_data_out", 32'(bus.data_out), 32'h0);
    check("rst_digit_sel", 32'(bus.digit_sel), 32'h0);
    check("rst_frame_tick", 32'(bus.frame_tick), 32'h0);
    check("rst_update_pending", 32'(bus.update_pending), 32'h0);

    // Release reset and start scanning; cycle i = state after edge i.
    reset  = 1'b0;
    bus.en = 1'b1;

    for (int i = 1; i <= 96; i++) begin
      step();
      if (i <= 73)      eff = i;
      else if (i <= 83) eff = 73;
      else              eff = i - 10;
      exp_ft = ((i <= 73) && (i % 16 == 0)) || ((i >= 84) && ((i - 10) % 16 == 0));
      check($sformatf("digit_sel@%0d", i), 32'(bus.digit_sel), 32'((eff / 4) % 4));
      check($sformatf("frame_tick@%0d", i), 32'(bus.frame_tick), 32'(exp_ft));

      case (i)
        4:  begin check("up@4", 32'(bus.update_pending), 32'h1);
                  check("dout@4", 32'(bus.data_out), 32'h0); end
        15: check("dout@15", 32'(bus.data_out), 32'h0);
        16: begin check("dout@16", 32'(bus.data_out), 32'h1234);
                  check("up@16", 32'(bus.update_pending), 32'h0); end
        22: check("up@22", 32'(bus.update_pending), 32'h1);
        31: check("dout@31", 32'(bus.data_out), 32'h1234);
        32: begin check("dout@32", 32'(bus.data_out), 32'h5555);
                  check("up@32", 32'(bus.update_pending), 32'h0); end
        47: begin check("dout@47", 32'(bus.data_out), 32'h5555);
                  check("up@47", 32'(bus.update_pending), 32'h1); end
        48: begin check("dout@48", 32'(bus.data_out), 32'h1111);
                  check("up@48", 32'(bus.update_pending), 32'h1); end
        63: check("dout@63", 32'(bus.data_out), 32'h1111);
        64: begin check("dout@64", 32'(bus.data_out), 32'h2222);
                  check("up@64", 32'(bus.update_pending), 32'h0); end
        76: begin check("up@76", 32'(bus.update_pending), 32'h1);
                  check("dout@76", 32'(bus.data_out), 32'h2222); end
        89: check("dout@89", 32'(bus.data_out), 32'h2222);
        90: begin check("dout@90", 32'(bus.data_out), 32'h3333);
                  check("up@90", 32'(bus.update_pending), 32'h0); end
        94: check("up@94", 32'(bus.update_pending), 32'h1);
        default: ;
      endcase

      // Drive inputs for the next edge.
      bus.load = 1'b0;
      case (i)
        3:  begin bus.load = 1'b1; bus.data_in = 16'h1234; end
        21: begin bus.load = 1'b1; bus.data_in = 16'hAAAA; end
        25: begin bus.load = 1'b1; bus.data_in = 16'h5555; end
        36: begin bus.load = 1'b1; bus.data_in = 16'h1111; end
        47: begin bus.load = 1'b1; bus.data_in = 16'h2222; end
        75: begin bus.load = 1'b1; bus.data_in = 16'h3333; end
        93: begin bus.load = 1'b1; bus.data_in = 16'h4444; end
        default: ;
      endcase
      bus.en = !((i >= 73) && (i <= 82));
    end

    // Asynchronous reset between edges with a word shown and another pending.
    #2;
    reset = 1'b1;
    #1;
    check("arst_data_out", 32'(bus.data_out), 32'h0);
    check("arst_digit_sel", 32'(bus.digit_sel), 32'h0);
    check("arst_frame_tick", 32'(bus.frame_tick), 32'h0);
    check("arst_update_pending", 32'(bus.update_pending), 32'h0);

    step();
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 16) begin
        check("post_rst_frame_tick", 32'(bus.frame_tick), 32'h1);
        check("post_rst_data_out", 32'(bus.data_out), 32'h0);
        check("post_rst_update_pending", 32'(bus.update_pending), 32'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
